// File: rtl/bypass_unit_pkg.sv
// Shared definitions for the operand bypass network and the hazard logic.
package bypass_unit_pkg;

    localparam int BU_XLEN   = 32;
    localparam int BU_REG_AW = 5;

    // Operand source select encodings (also exported for observability)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_E  = 2'b11;

    // Source-read enables: bit0 = rs1, bit1 = rs2
    localparam logic [1:0] REG_RD_NONE = 2'b00;
    localparam logic [1:0] REG_RD_RS1  = 2'b01;
    localparam logic [1:0] REG_RD_RS2  = 2'b10;
    localparam logic [1:0] REG_RD_BOTH = 2'b11;

    // Destination tag carried down the shadow pipeline
    typedef struct packed {
        logic                 we;
        logic [BU_REG_AW-1:0] rd;
        logic                 ld;
    } stage_tag_t;

    // A stage produces a value for src; x0 is never produced
    function automatic logic tag_hit(stage_tag_t tag, logic [BU_REG_AW-1:0] src);
        return tag.we && (tag.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/bypass_unit_if.sv
// Decode-side bus between the core and the bypass unit.
interface bypass_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) ();
    logic              reg_WE;
    logic              is_load;
    logic [1:0]        reg_RD;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rs3;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;
    logic [XLEN-1:0]   result_E;
    logic [XLEN-1:0]   result_M;
    logic [XLEN-1:0]   result_WB;
    logic              stall_D;
    logic              flush_E;
    logic              flush_M;
    logic [XLEN-1:0]   opa_data;
    logic [XLEN-1:0]   opb_data;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              load_use_stall;

    modport master (
        output reg_WE, is_load, reg_RD, rs1, rs2, rs3,
        output rf_rs1_data, rf_rs2_data, result_E, result_M, result_WB,
        output stall_D, flush_E, flush_M,
        input  opa_data, opb_data, fwd_a_sel, fwd_b_sel, load_use_stall
    );

    modport slave (
        input  reg_WE, is_load, reg_RD, rs1, rs2, rs3,
        input  rf_rs1_data, rf_rs2_data, result_E, result_M, result_WB,
        input  stall_D, flush_E, flush_M,
        output opa_data, opb_data, fwd_a_sel, fwd_b_sel, load_use_stall
    );
endinterface

// File: rtl/bypass_unit_mux.sv
// Priority compare and data select for one decode operand.
module bypass_mux
    import bypass_unit_pkg::*;
#(
    parameter int XLEN = BU_XLEN
) (
    input  logic                 en_i,
    input  logic [BU_REG_AW-1:0] src_i,
    input  stage_tag_t           tag_e_i,
    input  stage_tag_t           tag_m_i,
    input  stage_tag_t           tag_wb_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic [XLEN-1:0]      res_e_i,
    input  logic [XLEN-1:0]      res_m_i,
    input  logic [XLEN-1:0]      res_wb_i,
    output logic [XLEN-1:0]      data_o,
    output logic [1:0]           sel_o,
    output logic                 load_use_o
);

    // Youngest producer wins; a load still in E flags a stall (its data is unusable)
    always_comb begin
        sel_o      = FWD_RF;
        data_o     = rf_data_i;
        load_use_o = 1'b0;
        if (en_i) begin
            if (tag_hit(tag_e_i, src_i)) begin
                sel_o      = FWD_E;
                data_o     = res_e_i;
                load_use_o = tag_e_i.ld;
            end else if (tag_hit(tag_m_i, src_i)) begin
                sel_o  = FWD_M;
                data_o = res_m_i;
            end else if (tag_hit(tag_wb_i, src_i)) begin
                sel_o  = FWD_WB;
                data_o = res_wb_i;
            end
        end
    end

endmodule

// File: rtl/bypass_unit.sv
// Forwards in-flight results onto decode operands using an E/M/WB tag shadow pipeline.
module bypass_unit
    import bypass_unit_pkg::*;
#(
    parameter int XLEN   = BU_XLEN,
    parameter int REG_AW = BU_REG_AW   // tag width follows BU_REG_AW in the package
) (
    input logic          clk,
    input logic          rst_n,
    bypass_unit_if.slave bus
);

    stage_tag_t e_q, m_q, wb_q;
    stage_tag_t e_d, m_d, wb_d;

    logic [REG_AW-1:0] src      [2];
    logic [XLEN-1:0]   rf_data  [2];
    logic [XLEN-1:0]   op_data  [2];
    logic [1:0]        op_sel   [2];
    logic              op_lu    [2];
    logic              load_use;

    assign src[0]     = bus.rs1;
    assign src[1]     = bus.rs2;
    assign rf_data[0] = bus.rf_rs1_data;
    assign rf_data[1] = bus.rf_rs2_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            bypass_mux #(.XLEN(XLEN)) u_mux (
                .en_i       (bus.reg_RD[gi]),
                .src_i      (src[gi]),
                .tag_e_i    (e_q),
                .tag_m_i    (m_q),
                .tag_wb_i   (wb_q),
                .rf_data_i  (rf_data[gi]),
                .res_e_i    (bus.result_E),
                .res_m_i    (bus.result_M),
                .res_wb_i   (bus.result_WB),
                .data_o     (op_data[gi]),
                .sel_o      (op_sel[gi]),
                .load_use_o (op_lu[gi])
            );
        end
    endgenerate

    assign load_use           = op_lu[0] | op_lu[1];
    assign bus.load_use_stall = load_use;
    assign bus.opa_data       = op_data[0];
    assign bus.opb_data       = op_data[1];
    assign bus.fwd_a_sel      = op_sel[0];
    assign bus.fwd_b_sel      = op_sel[1];

    // Next tags: flush, load-use and decode stall all inject a bubble into E; x0 writes are dropped
    always_comb begin
        e_d = '0;
        if (!(bus.flush_E || load_use || bus.stall_D)) begin
            e_d.we = bus.reg_WE && (bus.rs3 != '0);
            e_d.rd = bus.rs3;
            e_d.ld = bus.is_load;
        end
        m_d  = bus.flush_M ? '0 : e_q;
        wb_d = m_q;
    end

    // Shadow pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q  <= '0;
            m_q  <= '0;
            wb_q <= '0;
        end else begin
            e_q  <= e_d;
            m_q  <= m_d;
            wb_q <= wb_d;
        end
    end

endmodule

// File: tb/tb_bypass_unit.sv
// Directed tests for bypass_unit: reset, forwarding paths, priority, load-use, x0, flushes.
module tb_bypass_unit;
    import bypass_unit_pkg::*;

    localparam logic [31:0] RF1 = 32'hAAAA_0001;
    localparam logic [31:0] RF2 = 32'hBBBB_0002;
    localparam logic [31:0] RE  = 32'hEEEE_0003;
    localparam logic [31:0] RM  = 32'hDDDD_0004;
    localparam logic [31:0] RW  = 32'hCCCC_0005;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    bypass_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

    bypass_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.reg_WE = 0; bus.is_load = 0; bus.reg_RD = REG_RD_NONE;
        bus.rs1 = 0; bus.rs2 = 0; bus.rs3 = 0;
        bus.rf_rs1_data = RF1; bus.rf_rs2_data = RF2;
        bus.result_E = RE; bus.result_M = RM; bus.result_WB = RW;
        bus.stall_D = 0; bus.flush_E = 0; bus.flush_M = 0;
    endtask

    // Advance one edge, then leave a margin before touching inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        idle();
        bus.reg_WE = 1; bus.rs3 = rd; bus.is_load = ld;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.reg_WE = 1; bus.is_load = 1; bus.reg_RD = REG_RD_BOTH;
        bus.rs1 = 5; bus.rs2 = 6; bus.rs3 = 5;
        bus.rf_rs1_data = $urandom; bus.rf_rs2_data = $urandom;
        bus.result_E = $urandom; bus.result_M = $urandom; bus.result_WB = $urandom;
        bus.stall_D = 0; bus.flush_E = 0; bus.flush_M = 0;
        repeat (3) tick();
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL reset_sel_a got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        compared++; if (bus.fwd_b_sel !== FWD_RF) begin mismatched++; $display("FAIL reset_sel_b got=%b exp=%b", bus.fwd_b_sel, FWD_RF); end
        compared++; if (bus.load_use_stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b exp=0", bus.load_use_stall); end
        compared++; if (bus.opa_data !== bus.rf_rs1_data) begin mismatched++; $display("FAIL reset_opa got=%h exp=%h", bus.opa_data, bus.rf_rs1_data); end
        idle();
        rst_n = 1;
        bus.rs1 = 5; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL post_reset_sel_a got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        $display("test_reset done");
        drain();
    endtask

    task automatic test_e_forward();
        issue(5, 0);
        bus.rs1 = 5; bus.rs2 = 5; bus.reg_RD = REG_RD_RS1; bus.result_E = 32'h1234;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_E) begin mismatched++; $display("FAIL efwd_sel_a got=%b exp=%b", bus.fwd_a_sel, FWD_E); end
        compared++; if (bus.opa_data !== 32'h1234) begin mismatched++; $display("FAIL efwd_opa got=%h exp=%h", bus.opa_data, 32'h1234); end
        compared++; if (bus.fwd_b_sel !== FWD_RF) begin mismatched++; $display("FAIL efwd_sel_b got=%b exp=%b", bus.fwd_b_sel, FWD_RF); end
        compared++; if (bus.opb_data !== RF2) begin mismatched++; $display("FAIL efwd_opb got=%h exp=%h", bus.opb_data, RF2); end
        compared++; if (bus.load_use_stall !== 1'b0) begin mismatched++; $display("FAIL efwd_stall got=%b exp=0", bus.load_use_stall); end
        $display("test_e_forward done");
        drain();
    endtask

    task automatic test_priority();
        idle(); bus.reg_WE = 1; bus.rs3 = 7; tick();
        issue(7, 0);
        bus.rs2 = 7; bus.reg_RD = REG_RD_RS2; bus.result_E = 32'hA; bus.result_M = 32'hB;
        #1;
        compared++; if (bus.fwd_b_sel !== FWD_E) begin mismatched++; $display("FAIL prio_e_sel got=%b exp=%b", bus.fwd_b_sel, FWD_E); end
        compared++; if (bus.opb_data !== 32'hA) begin mismatched++; $display("FAIL prio_e_opb got=%h exp=%h", bus.opb_data, 32'hA); end
        tick();
        bus.rs2 = 7; bus.reg_RD = REG_RD_RS2; bus.result_E = 32'hA; bus.result_M = 32'hB;
        #1;
        compared++; if (bus.fwd_b_sel !== FWD_M) begin mismatched++; $display("FAIL prio_m_sel got=%b exp=%b", bus.fwd_b_sel, FWD_M); end
        compared++; if (bus.opb_data !== 32'hB) begin mismatched++; $display("FAIL prio_m_opb got=%h exp=%h", bus.opb_data, 32'hB); end
        tick();
        bus.rs2 = 7; bus.reg_RD = REG_RD_RS2;
        #1;
        compared++; if (bus.fwd_b_sel !== FWD_WB) begin mismatched++; $display("FAIL prio_wb_sel got=%b exp=%b", bus.fwd_b_sel, FWD_WB); end
        compared++; if (bus.opb_data !== RW) begin mismatched++; $display("FAIL prio_wb_opb got=%h exp=%h", bus.opb_data, RW); end
        tick();
        bus.rs2 = 7; bus.reg_RD = REG_RD_RS2;
        #1;
        compared++; if (bus.fwd_b_sel !== FWD_RF) begin mismatched++; $display("FAIL prio_retired_sel got=%b exp=%b", bus.fwd_b_sel, FWD_RF); end
        $display("test_priority done");
        drain();
    endtask

    task automatic test_load_use();
        issue(3, 1);
        bus.rs1 = 3; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.load_use_stall !== 1'b1) begin mismatched++; $display("FAIL lu_stall got=%b exp=1", bus.load_use_stall); end
        compared++; if (bus.fwd_a_sel !== FWD_E) begin mismatched++; $display("FAIL lu_sel_a got=%b exp=%b", bus.fwd_a_sel, FWD_E); end
        tick();
        bus.rs1 = 3; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.load_use_stall !== 1'b0) begin mismatched++; $display("FAIL lu_stall_clear got=%b exp=0", bus.load_use_stall); end
        compared++; if (bus.fwd_a_sel !== FWD_M) begin mismatched++; $display("FAIL lu_sel_m got=%b exp=%b", bus.fwd_a_sel, FWD_M); end
        compared++; if (bus.opa_data !== RM) begin mismatched++; $display("FAIL lu_opa got=%h exp=%h", bus.opa_data, RM); end
        $display("test_load_use done");
        drain();
        issue(3, 1);
        bus.rs2 = 3; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.load_use_stall !== 1'b0) begin mismatched++; $display("FAIL lu_disabled_stall got=%b exp=0", bus.load_use_stall); end
        drain();
    endtask

    task automatic test_x0_disabled();
        issue(0, 0);
        bus.rs1 = 0; bus.reg_RD = REG_RD_RS1; bus.rf_rs1_data = 32'h0;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL x0_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        compared++; if (bus.opa_data !== 32'h0) begin mismatched++; $display("FAIL x0_opa got=%h exp=0", bus.opa_data); end
        drain();
        issue(9, 0);
        bus.rs1 = 9; bus.rs2 = 9; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_b_sel !== FWD_RF) begin mismatched++; $display("FAIL dis_sel_b got=%b exp=%b", bus.fwd_b_sel, FWD_RF); end
        compared++; if (bus.fwd_a_sel !== FWD_E) begin mismatched++; $display("FAIL dis_sel_a got=%b exp=%b", bus.fwd_a_sel, FWD_E); end
        $display("test_x0_disabled done");
        drain();
    endtask

    task automatic test_flush();
        idle(); bus.reg_WE = 1; bus.rs3 = 4; bus.flush_E = 1; tick(); idle();
        bus.rs1 = 4; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL flushE_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        drain();
        issue(4, 0);
        bus.flush_M = 1; tick(); idle();
        bus.rs1 = 4; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL flushM_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        tick();
        bus.rs1 = 4; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL flushM_wb_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        drain();
        idle(); bus.reg_WE = 1; bus.rs3 = 4; bus.stall_D = 1; tick(); idle();
        bus.rs1 = 4; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL stallD_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        $display("test_flush done");
        drain();
    endtask

    task automatic test_async_reset();
        issue(6, 0);
        bus.rs1 = 6; bus.reg_RD = REG_RD_RS1;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_E) begin mismatched++; $display("FAIL areset_pre_sel got=%b exp=%b", bus.fwd_a_sel, FWD_E); end
        rst_n = 0;
        #1;
        compared++; if (bus.fwd_a_sel !== FWD_RF) begin mismatched++; $display("FAIL areset_sel got=%b exp=%b", bus.fwd_a_sel, FWD_RF); end
        compared++; if (bus.opa_data !== RF1) begin mismatched++; $display("FAIL areset_opa got=%h exp=%h", bus.opa_data, RF1); end
        idle();
        #1 rst_n = 1;
        tick();
        $display("test_async_reset done");
        drain();
    endtask

    initial begin
        idle();
        test_reset();
        test_e_forward();
        test_priority();
        test_load_use();
        test_x0_disabled();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
